muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply / divide / multiply-accumulate unit.
// A multiply takes WIDTH cycles of radix-2 shift-add and a divide takes WIDTH
// cycles of restoring shift-subtract, both on operand magnitudes. One FIX cycle
// then applies sign correction and the accumulate, and one DONE cycle presents
// the result.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start_i      start a new operation (only honoured in IDLE)
//   op_i         000 MULT 001 MULTU 010 DIV 011 DIVU 100 MADD 101 MADDU 110 MSUB 111 MSUBU
//   opdata1_i    dividend / multiplicand
//   opdata2_i    divisor / multiplier
//   hi_i, lo_i   accumulator, captured for MADD/MSUB
//   annul_i      flush the operation in flight
//   busy_o       state != IDLE
//   ready_o      one-cycle pulse, result valid on hi_o/lo_o in the same cycle
//   hi_o, lo_o   result (divide: remainder / quotient)
//   div_zero_o   last completed divide had a zero divisor
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] opdata1_i,
   input  logic [WIDTH-1:0] opdata2_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic             annul_i,
   output logic             busy_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             div_zero_o
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           op_q, op_d;
   logic [WIDTH-1:0]     m_q, m_d;        // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0]   p_q, p_d;        // working product / {remainder, quotient}, then result
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic                 negp_q, negp_d;  // negate product or quotient
   logic                 negr_q, negr_d;  // negate remainder
   logic                 dzp_q, dzp_d;    // divide-by-zero pending for DONE
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic                 dz_q, dz_d;

   logic                 s1, s2;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       msum, dshift, ddiff;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quo, rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         m_q     <= '0;
         p_q     <= '0;
         acc_q   <= '0;
         negp_q  <= 1'b0;
         negr_q  <= 1'b0;
         dzp_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         m_q     <= m_d;
         p_q     <= p_d;
         acc_q   <= acc_d;
         negp_q  <= negp_d;
         negr_q  <= negr_d;
         dzp_q   <= dzp_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      m_d     = m_q;
      p_d     = p_q;
      acc_d   = acc_q;
      negp_d  = negp_q;
      negr_d  = negr_q;
      dzp_d   = dzp_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
      ready_o = 1'b0;

      // Operand magnitudes; op_i[0]=0 selects the signed variant.
      s1    = ~op_i[0] & opdata1_i[WIDTH-1];
      s2    = ~op_i[0] & opdata2_i[WIDTH-1];
      a_mag = s1 ? ('0 - opdata1_i) : opdata1_i;
      b_mag = s2 ? ('0 - opdata2_i) : opdata2_i;

      // One multiply step: add multiplicand on multiplier LSB, shift right.
      msum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
      // One divide step: shift {rem, quo} left, trial subtract.
      dshift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
      ddiff  = dshift - {1'b0, m_q};

      prod = negp_q ? ('0 - p_q) : p_q;
      quo  = negp_q ? ('0 - p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
      rem  = negr_q ? ('0 - p_q[2*WIDTH-1:WIDTH]) : p_q[2*WIDTH-1:WIDTH];

      unique case (state_q)
         IDLE: begin
            if (start_i && !annul_i) begin
               op_d   = op_i;
               acc_d  = {hi_i, lo_i};
               cnt_d  = '0;
               dzp_d  = 1'b0;
               negp_d = s1 ^ s2;
               negr_d = s1;
               state_d = CALC;
               if (op_i[2:1] == 2'b01) begin
                  m_d = b_mag;
                  p_d = {{WIDTH{1'b0}}, a_mag};
                  if (opdata2_i == '0) begin
                     p_d     = '0;
                     dzp_d   = 1'b1;
                     state_d = DONE;
                  end
               end else begin
                  m_d = a_mag;
                  p_d = {{WIDTH{1'b0}}, b_mag};
               end
            end
         end
         CALC: begin
            if (annul_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               if (op_q[2:1] == 2'b01) begin
                  if (!ddiff[WIDTH])
                     p_d = {ddiff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
                  else
                     p_d = {dshift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
               end else begin
                  p_d = {msum, p_q[WIDTH-1:1]};
               end
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = FIX;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         FIX: begin
            if (annul_i) begin
               state_d = IDLE;
            end else begin
               if (op_q[2:1] == 2'b01)
                  p_d = {rem, quo};
               else if (op_q[2])
                  p_d = op_q[1] ? (acc_q - prod) : (acc_q + prod);
               else
                  p_d = prod;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!annul_i) begin
               ready_o = 1'b1;
               hi_d    = p_q[2*WIDTH-1:WIDTH];
               lo_d    = p_q[WIDTH-1:0];
               dz_d    = dzp_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The committed value is bypassed onto the outputs during DONE so that it
   // coincides with ready_o; the registers hold it from then on.
   assign hi_o       = hi_d;
   assign lo_o       = lo_d;
   assign div_zero_o = dz_d;
   assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_i;
   logic [2:0]   op_i;
   logic [W-1:0] opdata1_i, opdata2_i, hi_i, lo_i;
   logic         annul_i;
   logic         busy_o, ready_o, div_zero_o;
   logic [W-1:0] hi_o, lo_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] prev_hi, prev_lo;
   logic         prev_dz;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .op_i       (op_i),
      .opdata1_i  (opdata1_i),
      .opdata2_i  (opdata2_i),
      .hi_i       (hi_i),
      .lo_i       (lo_i),
      .annul_i    (annul_i),
      .busy_o     (busy_o),
      .ready_o    (ready_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o),
      .div_zero_o (div_zero_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_held(input string tag);
      check({tag, "/hi"}, 64'(hi_o), 64'(prev_hi));
      check({tag, "/lo"}, 64'(lo_o), 64'(prev_lo));
      check({tag, "/dz"}, 64'(div_zero_o), 64'(prev_dz));
   endtask

   // Issue one operation and check result and latency (cycles from the start edge).
   // poke > 0 re-asserts start_i (as a divide by zero) in that busy cycle.
   task automatic run_op(input string tag, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] h, input logic [W-1:0] l,
                         input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic edz, input int elat, input int poke);
      int  k;
      bit  seen;
      @(negedge clk);
      op_i = op; opdata1_i = a; opdata2_i = b; hi_i = h; lo_i = l; start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i   = 1'b0;
      op_i      = 3'($urandom_range(0, 7));
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      hi_i      = $urandom;
      lo_i      = $urandom;
      seen = 1'b0;
      k    = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         start_i = 1'b0;
         if (c == 1) check({tag, "/busy"}, 64'(busy_o), 64'(1));
         if (ready_o) begin
            seen = 1'b1;
            k    = c;
            break;
         end
         if (c == poke) begin
            start_i = 1'b1; op_i = 3'b011; opdata2_i = '0;
         end
      end
      start_i = 1'b0;
      check({tag, "/ready"}, 64'(seen), 64'(1));
      if (seen) begin
         check({tag, "/latency"}, 64'(k), 64'(elat));
         check({tag, "/hi"}, 64'(hi_o), 64'(eh));
         check({tag, "/lo"}, 64'(lo_o), 64'(el));
         check({tag, "/dz"}, 64'(div_zero_o), 64'(edz));
      end
      @(negedge clk);
      check({tag, "/ready_end"}, 64'(ready_o), 64'(0));
      check({tag, "/busy_end"}, 64'(busy_o), 64'(0));
      check({tag, "/hi_held"}, 64'(hi_o), 64'(eh));
      check({tag, "/lo_held"}, 64'(lo_o), 64'(el));
      prev_hi = eh; prev_lo = el; prev_dz = edz;
   endtask

   initial begin
      bit seen;
      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = '0;
      opdata1_i = '0; opdata2_i = '0; hi_i = '0; lo_i = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst/busy",  64'(busy_o), 64'(0));
      check("rst/ready", 64'(ready_o), 64'(0));
      check("rst/hi",    64'(hi_o), 64'(0));
      check("rst/lo",    64'(lo_o), 64'(0));
      check("rst/dz",    64'(div_zero_o), 64'(0));

      run_op("mult_neg",   3'b000, 32'hFFFFFFFE, 32'h3, '0, '0, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, W+2, 0);
      run_op("div_m7_2",   3'b010, 32'hFFFFFFF9, 32'h2, '0, '0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W+2, 0);
      run_op("divu_big",   3'b011, 32'h80000000, 32'h3, '0, '0, 32'h2, 32'h2AAAAAAA, 1'b0, W+2, 0);
      run_op("divu_zero",  3'b011, 32'h1234, 32'h0, '0, '0, 32'h0, 32'h0, 1'b1, 1, 0);
      run_op("multu_2x3",  3'b001, 32'h2, 32'h3, '0, '0, 32'h0, 32'h6, 1'b0, W+2, 5);
      run_op("msubu",      3'b111, 32'h3, 32'h2, 32'h0, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, W+2, 0);
      run_op("madd",       3'b100, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 1'b0, W+2, 0);
      run_op("div_wrap",   3'b010, 32'h80000000, 32'hFFFFFFFF, '0, '0, 32'h0, 32'h80000000, 1'b0, W+2, 0);
      run_op("div_7_m2",   3'b010, 32'h7, 32'hFFFFFFFE, '0, '0, 32'h1, 32'hFFFFFFFD, 1'b0, W+2, 0);
      run_op("mult_minmin",3'b000, 32'h80000000, 32'h80000000, '0, '0, 32'h40000000, 32'h0, 1'b0, W+2, 0);
      run_op("multu_max",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 32'hFFFFFFFE, 32'h1, 1'b0, W+2, 0);
      run_op("msub",       3'b110, 32'hFFFFFFFE, 32'h3, 32'h0, 32'h0, 32'h0, 32'h6, 1'b0, W+2, 0);

      // Annul in CALC cycle 10: back to IDLE, no ready, outputs held.
      @(negedge clk);
      op_i = 3'b001; opdata1_i = 32'h5; opdata2_i = 32'h7; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      seen = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (ready_o) seen = 1'b1;
         if (c == 10) annul_i = 1'b1;
      end
      @(posedge clk);
      #1 annul_i = 1'b0;
      @(negedge clk);
      check("annul_calc/busy", 64'(busy_o), 64'(0));
      check_held("annul_calc");
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready_o) seen = 1'b1;
      end
      check("annul_calc/no_ready", 64'(seen), 64'(0));
      check_held("annul_calc_late");

      // Annul in DONE (divide by zero reaches DONE immediately).
      @(negedge clk);
      op_i = 3'b011; opdata1_i = 32'h1234; opdata2_i = 32'h0; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0; annul_i = 1'b1;
      @(negedge clk);
      check("annul_done/busy", 64'(busy_o), 64'(1));
      check("annul_done/ready", 64'(ready_o), 64'(0));
      check_held("annul_done");
      @(posedge clk);
      #1 annul_i = 1'b0;
      @(negedge clk);
      check("annul_done/busy_after", 64'(busy_o), 64'(0));
      check_held("annul_done_after");

      // start_i together with annul_i in IDLE is ignored.
      @(negedge clk);
      op_i = 3'b001; opdata1_i = 32'h2; opdata2_i = 32'h3; start_i = 1'b1; annul_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0; annul_i = 1'b0;
      @(negedge clk);
      check("start_annul/busy", 64'(busy_o), 64'(0));
      check("start_annul/ready", 64'(ready_o), 64'(0));

      // Reset in CALC cycle 5 discards the operation and clears outputs.
      @(negedge clk);
      op_i = 3'b010; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 5) rst = 1'b1;
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_mid/busy",  64'(busy_o), 64'(0));
      check("rst_mid/ready", 64'(ready_o), 64'(0));
      check("rst_mid/hi",    64'(hi_o), 64'(0));
      check("rst_mid/lo",    64'(lo_o), 64'(0));
      check("rst_mid/dz",    64'(div_zero_o), 64'(0));
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready_o) seen = 1'b1;
      end
      check("rst_mid/no_ready", 64'(seen), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
